// File: rtl/dbi_pkg.sv
// dbi_pkg: shared types and constants for the DBI frame sequencer.
//   dbi_state_e  - sequencer FSM states (RST_WAIT only with DBI_RST_WAIT_EN)
//   DCX_CMD/DCX_DATA - D/CX flag values
//   PARAM_CNT_W  - width of the parameter-byte index
package dbi_pkg;

  localparam logic        DCX_CMD     = 1'b0;
  localparam logic        DCX_DATA    = 1'b1;
  localparam int unsigned PARAM_CNT_W = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SWRST,
`ifdef DBI_RST_WAIT_EN
    ST_RST_WAIT,
`endif
    ST_DISPON,
    ST_CASET,
    ST_CASET_P,
    ST_PASET,
    ST_PASET_P,
    ST_MADCTL,
    ST_MADCTL_P,
    ST_RAMWR,
    ST_PIXEL,
    ST_DONE
  } dbi_state_e;

endpackage

// File: rtl/dbi_byte_out_stage.sv
// dbi_byte_out_stage: single registered valid/ready entry holding one byte + D/CX.
//   clk, rst_n        clock, async active-low reset
//   load_i            load data_i/dcx_i (only asserted while load_ok_o)
//   data_i, dcx_i     byte and D/CX flag to load
//   load_ok_o         combinational: entry empty or draining this cycle
//   tx_data_o, tx_dcx_o, tx_valid_o, tx_ready_i  registered PHY-side handshake
module dbi_byte_out_stage #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              dcx_i,
  output logic              load_ok_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_dcx_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              dcx_q;

  assign load_ok_o = ~valid_q | tx_ready_i;

  // Data/dcx only change on load, so they stay put while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      dcx_q   <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      dcx_q   <= dcx_i;
    end else if (tx_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign tx_valid_o = valid_q;
  assign tx_data_o  = data_q;
  assign tx_dcx_o   = dcx_q;

endmodule

// File: rtl/dbi_frame_sequencer.sv
// dbi_frame_sequencer: emits one DBI frame update (init cmds, window, MADCTL,
// RAMWR, pixel stream) to the DBI TX PHY on each rising edge of dbi_tx_start_i.
//   dbi_tx_start_i              level start; rising edge starts a frame in IDLE
//   addr_*_i, cmd_*_i           opcodes / parameters, snapshotted at start
//   pix_data_i/valid_i/last_i   pixel source, pix_ready_o (comb, PIXEL only)
//   tx_data_o/dcx_o/valid_o     registered byte to PHY, tx_ready_i from PHY
//   busy_o                      sequencer not IDLE
//   frame_done_o                one-cycle pulse at frame end
// Build option: DBI_RST_WAIT_EN adds an RST_WAIT_CYC-cycle wait after SWRST.
module dbi_frame_sequencer
  import dbi_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned RST_WAIT_CYC = 600000,
  parameter int unsigned RST_WAIT_W   = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dbi_tx_start_i,
  input  logic [DATA_W-1:0] addr_soft_rst_i,
  input  logic [DATA_W-1:0] addr_disp_on_i,
  input  logic [DATA_W-1:0] addr_col_i,
  input  logic [DATA_W-1:0] addr_row_i,
  input  logic [DATA_W-1:0] addr_acs_ctrl_i,
  input  logic [DATA_W-1:0] addr_mem_wr_i,
  input  logic [DATA_W-1:0] cmd_s_col_h_i,
  input  logic [DATA_W-1:0] cmd_s_col_l_i,
  input  logic [DATA_W-1:0] cmd_e_col_h_i,
  input  logic [DATA_W-1:0] cmd_e_col_l_i,
  input  logic [DATA_W-1:0] cmd_s_row_h_i,
  input  logic [DATA_W-1:0] cmd_s_row_l_i,
  input  logic [DATA_W-1:0] cmd_e_row_h_i,
  input  logic [DATA_W-1:0] cmd_e_row_l_i,
  input  logic [DATA_W-1:0] cmd_acs_ctrl_i,
  input  logic [DATA_W-1:0] pix_data_i,
  input  logic              pix_valid_i,
  input  logic              pix_last_i,
  output logic              pix_ready_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_dcx_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              frame_done_o
);

  // Wait counter must be able to hold RST_WAIT_CYC.
  if ((64'(1) << RST_WAIT_W) <= 64'(RST_WAIT_CYC)) begin : g_wait_w_chk
    $error("RST_WAIT_W too small for RST_WAIT_CYC");
  end

  dbi_state_e               state_q, state_d;
  logic [PARAM_CNT_W-1:0]   idx_q, idx_d;
  logic                     init_done_q, init_done_d;
  logic                     start_q, busy_q, frame_done_q;
  logic                     start_pls, snap_c, load_c, load_ok, dcx_c, pix_ready_c;
  logic [DATA_W-1:0]        byte_c;

  logic [DATA_W-1:0] swrst_q, dispon_q, caset_q, paset_q, madctl_q, ramwr_q, acs_q;
  logic [DATA_W-1:0] col_q [4];
  logic [DATA_W-1:0] row_q [4];

`ifdef DBI_RST_WAIT_EN
  localparam logic [RST_WAIT_W-1:0] WAIT_LAST = RST_WAIT_W'(RST_WAIT_CYC - 1);
  logic [RST_WAIT_W-1:0] cnt_q, cnt_d;
`endif

  assign start_pls = dbi_tx_start_i & ~start_q;

  // Next-state, byte selection and handshake control.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    snap_c      = 1'b0;
    load_c      = 1'b0;
    byte_c      = '0;
    dcx_c       = DCX_CMD;
    pix_ready_c = 1'b0;
`ifdef DBI_RST_WAIT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_pls) begin
          snap_c  = 1'b1;
          idx_d   = '0;
          state_d = init_done_q ? ST_CASET : ST_SWRST;
        end
      end
      ST_SWRST: begin
        load_c = load_ok;
        byte_c = swrst_q;
        if (load_ok) begin
`ifdef DBI_RST_WAIT_EN
          cnt_d   = '0;
          state_d = ST_RST_WAIT;
`else
          state_d = ST_DISPON;
`endif
        end
      end
`ifdef DBI_RST_WAIT_EN
      // Counts only once the SWRST byte has left (or is leaving) the stage.
      ST_RST_WAIT: begin
        if (load_ok) begin
          if (cnt_q == WAIT_LAST) begin
            cnt_d   = '0;
            state_d = ST_DISPON;
          end else begin
            cnt_d = cnt_q + RST_WAIT_W'(1);
          end
        end
      end
`endif
      ST_DISPON: begin
        load_c = load_ok;
        byte_c = dispon_q;
        if (load_ok) begin
          init_done_d = 1'b1;
          state_d     = ST_CASET;
        end
      end
      ST_CASET: begin
        load_c = load_ok;
        byte_c = caset_q;
        if (load_ok) begin
          idx_d   = '0;
          state_d = ST_CASET_P;
        end
      end
      ST_CASET_P: begin
        load_c = load_ok;
        byte_c = col_q[idx_q];
        dcx_c  = DCX_DATA;
        if (load_ok) begin
          idx_d = idx_q + PARAM_CNT_W'(1);
          if (idx_q == '1) state_d = ST_PASET;
        end
      end
      ST_PASET: begin
        load_c = load_ok;
        byte_c = paset_q;
        if (load_ok) begin
          idx_d   = '0;
          state_d = ST_PASET_P;
        end
      end
      ST_PASET_P: begin
        load_c = load_ok;
        byte_c = row_q[idx_q];
        dcx_c  = DCX_DATA;
        if (load_ok) begin
          idx_d = idx_q + PARAM_CNT_W'(1);
          if (idx_q == '1) state_d = ST_MADCTL;
        end
      end
      ST_MADCTL: begin
        load_c = load_ok;
        byte_c = madctl_q;
        if (load_ok) state_d = ST_MADCTL_P;
      end
      ST_MADCTL_P: begin
        load_c = load_ok;
        byte_c = acs_q;
        dcx_c  = DCX_DATA;
        if (load_ok) state_d = ST_RAMWR;
      end
      ST_RAMWR: begin
        load_c = load_ok;
        byte_c = ramwr_q;
        if (load_ok) state_d = ST_PIXEL;
      end
      ST_PIXEL: begin
        pix_ready_c = load_ok;
        load_c      = load_ok & pix_valid_i;
        byte_c      = pix_data_i;
        dcx_c       = DCX_DATA;
        if (load_c && pix_last_i) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      init_done_q  <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      init_done_q  <= init_done_d;
      start_q      <= dbi_tx_start_i;
      busy_q       <= (state_d != ST_IDLE);
      frame_done_q <= (state_d == ST_DONE);
    end
  end

`ifdef DBI_RST_WAIT_EN
  // Post-SWRST wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  // Config shadow registers, captured on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swrst_q  <= '0;
      dispon_q <= '0;
      caset_q  <= '0;
      paset_q  <= '0;
      madctl_q <= '0;
      ramwr_q  <= '0;
      acs_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        col_q[i] <= '0;
        row_q[i] <= '0;
      end
    end else if (snap_c) begin
      swrst_q  <= addr_soft_rst_i;
      dispon_q <= addr_disp_on_i;
      caset_q  <= addr_col_i;
      paset_q  <= addr_row_i;
      madctl_q <= addr_acs_ctrl_i;
      ramwr_q  <= addr_mem_wr_i;
      acs_q    <= cmd_acs_ctrl_i;
      col_q[0] <= cmd_s_col_h_i;
      col_q[1] <= cmd_s_col_l_i;
      col_q[2] <= cmd_e_col_h_i;
      col_q[3] <= cmd_e_col_l_i;
      row_q[0] <= cmd_s_row_h_i;
      row_q[1] <= cmd_s_row_l_i;
      row_q[2] <= cmd_e_row_h_i;
      row_q[3] <= cmd_e_row_l_i;
    end
  end

  dbi_byte_out_stage #(.DATA_W(DATA_W)) u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_c),
    .data_i     (byte_c),
    .dcx_i      (dcx_c),
    .load_ok_o  (load_ok),
    .tx_data_o  (tx_data_o),
    .tx_dcx_o   (tx_dcx_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i)
  );

  assign pix_ready_o  = pix_ready_c;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_dbi_frame_sequencer.sv
// tb_dbi_frame_sequencer: table-driven frame vectors plus hand sequences,
// checked against a byte-list reference model of the DBI frame format.
module tb_dbi_frame_sequencer;

  localparam int unsigned DW       = 8;
  localparam int unsigned WAIT_CYC = 20;
`ifdef DBI_RST_WAIT_EN
  localparam int EXP_GAP = 20;
`else
  localparam int EXP_GAP = 0;
`endif

  typedef struct packed {
    logic [7:0] op_swrst, op_dispon, op_col, op_row, op_acs, op_memwr;
    logic [7:0] s_col_h, s_col_l, e_col_h, e_col_l;
    logic [7:0] s_row_h, s_row_l, e_row_h, e_row_l;
    logic [7:0] acs;
  } cfg_t;

  typedef struct {
    cfg_t       cfg;
    int         npix;
    bit         bp;
    bit         toggle;
    bit         exp_init;
    int         exp_count;
    logic [8:0] exp_first;
  } vec_t;

  logic          clk, rst_n, start;
  cfg_t          cfg;
  logic [DW-1:0] pix_data, tx_data;
  logic          pix_valid, pix_last, pix_ready, tx_dcx, tx_valid, tx_ready, busy, frame_done;

  int         n_chk = 0, n_pass = 0;
  bit         bp = 0;
  logic [7:0] pix_list[$];
  logic [7:0] pix_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] cap[$];
  int         fd_cnt = 0, gap = 0, gap_state = 0;

  dbi_frame_sequencer #(.DATA_W(DW), .RST_WAIT_CYC(WAIT_CYC), .RST_WAIT_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .dbi_tx_start_i(start),
    .addr_soft_rst_i(cfg.op_swrst), .addr_disp_on_i(cfg.op_dispon),
    .addr_col_i(cfg.op_col), .addr_row_i(cfg.op_row),
    .addr_acs_ctrl_i(cfg.op_acs), .addr_mem_wr_i(cfg.op_memwr),
    .cmd_s_col_h_i(cfg.s_col_h), .cmd_s_col_l_i(cfg.s_col_l),
    .cmd_e_col_h_i(cfg.e_col_h), .cmd_e_col_l_i(cfg.e_col_l),
    .cmd_s_row_h_i(cfg.s_row_h), .cmd_s_row_l_i(cfg.s_row_l),
    .cmd_e_row_h_i(cfg.e_row_h), .cmd_e_row_l_i(cfg.e_row_l),
    .cmd_acs_ctrl_i(cfg.acs),
    .pix_data_i(pix_data), .pix_valid_i(pix_valid), .pix_last_i(pix_last), .pix_ready_o(pix_ready),
    .tx_data_o(tx_data), .tx_dcx_o(tx_dcx), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .busy_o(busy), .frame_done_o(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic cfg_t spec_cfg();
    cfg_t c;
    c = '{op_swrst:8'h01, op_dispon:8'h29, op_col:8'h2A, op_row:8'h2B, op_acs:8'h36, op_memwr:8'h2C,
          s_col_h:8'h00, s_col_l:8'h00, e_col_h:8'h00, e_col_l:8'hEF,
          s_row_h:8'h00, s_row_l:8'h00, e_row_h:8'h01, e_row_l:8'h3F, acs:8'h48};
    return c;
  endfunction

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c = '{op_swrst:8'($urandom), op_dispon:8'($urandom), op_col:8'($urandom), op_row:8'($urandom),
          op_acs:8'($urandom), op_memwr:8'($urandom),
          s_col_h:8'($urandom), s_col_l:8'($urandom), e_col_h:8'($urandom), e_col_l:8'($urandom),
          s_row_h:8'($urandom), s_row_l:8'($urandom), e_row_h:8'($urandom), e_row_l:8'($urandom),
          acs:8'($urandom)};
    return c;
  endfunction

  // Reference model: the byte list a frame must produce, as {dcx, data}.
  task automatic make_exp(input cfg_t c, input bit init);
    exp_q.delete();
    if (init) begin
      exp_q.push_back({1'b0, c.op_swrst});
      exp_q.push_back({1'b0, c.op_dispon});
    end
    exp_q.push_back({1'b0, c.op_col});
    exp_q.push_back({1'b1, c.s_col_h}); exp_q.push_back({1'b1, c.s_col_l});
    exp_q.push_back({1'b1, c.e_col_h}); exp_q.push_back({1'b1, c.e_col_l});
    exp_q.push_back({1'b0, c.op_row});
    exp_q.push_back({1'b1, c.s_row_h}); exp_q.push_back({1'b1, c.s_row_l});
    exp_q.push_back({1'b1, c.e_row_h}); exp_q.push_back({1'b1, c.e_row_l});
    exp_q.push_back({1'b0, c.op_acs});
    exp_q.push_back({1'b1, c.acs});
    exp_q.push_back({1'b0, c.op_memwr});
    foreach (pix_list[i]) exp_q.push_back({1'b1, pix_list[i]});
  endtask

  // PHY ready driver.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = bp ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // Pixel source: holds valid until accepted.
  initial begin
    bit fire;
    pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0;
    forever begin
      @(negedge clk);
      fire = pix_valid & pix_ready;
      @(posedge clk); #1;
      if (fire && pix_q.size() > 0) pix_q.delete(0);
      if (pix_q.size() == 0) begin
        pix_valid = 1'b0;
        pix_last  = 1'b0;
      end else begin
        if (fire || !pix_valid) pix_valid = bp ? ($urandom_range(3) != 0) : 1'b1;
        pix_data = pix_q[0];
        pix_last = (pix_q.size() == 1);
      end
    end
  end

  // Monitor: captures accepted bytes, checks hold under stall, measures first gap.
  initial begin
    bit         stall_prev;
    logic [8:0] held;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
        continue;
      end
      if (stall_prev) check("stall_hold", {tx_valid, tx_dcx, tx_data}, {1'b1, held});
      stall_prev = tx_valid & ~tx_ready;
      held = {tx_dcx, tx_data};
      if (frame_done) fd_cnt++;
      if (gap_state == 1) begin
        if (tx_valid) gap_state = 2;
        else gap++;
      end
      if (tx_valid && tx_ready) begin
        cap.push_back({tx_dcx, tx_data});
        if (cap.size() == 1) begin
          gap_state = 1;
          gap = 0;
        end
      end
    end
  end

  task automatic load_frame(input vec_t v);
    cfg = v.cfg;
    bp  = v.bp;
    pix_list.delete();
    for (int i = 0; i < v.npix; i++) pix_list.push_back(8'($urandom));
    pix_q = pix_list;
    make_exp(v.cfg, v.exp_init);
    cap.delete();
    fd_cnt = 0;
    gap_state = 0;
  endtask

  task automatic run_frame(input string tag, input vec_t v);
    bit toggled;
    load_frame(v);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_lat1_valid"}, tx_valid, 0);
    check({tag, "_lat1_busy"}, busy, 1);
    @(posedge clk); #1;
    check({tag, "_lat2_valid"}, tx_valid, 1);
    check({tag, "_lat2_byte"}, {tx_dcx, tx_data}, v.exp_first);
    toggled = 1'b0;
    for (int cyc = 0; cyc < 3000 && fd_cnt == 0; cyc++) begin
      @(negedge clk);
      if (v.toggle && !toggled && cap.size() >= 14) begin
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        toggled = 1'b1;
      end
    end
    check({tag, "_done_seen"}, (fd_cnt != 0), 1);
    bp = 1'b0;
    repeat (12) @(negedge clk);
    check({tag, "_done_pulses"}, fd_cnt, 1);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_valid"}, tx_valid, 0);
    check({tag, "_byte_count"}, 32'(cap.size()), 32'(v.exp_count));
    check({tag, "_first_gap"}, gap, v.exp_init ? EXP_GAP : 0);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), (i < cap.size()) ? 32'(cap[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t v;
    cfg_t rc;
    int   n;
    start = 1'b0;
    cfg   = spec_cfg();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_dcx", tx_dcx, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    vecs[0] = '{cfg:spec_cfg(), npix:4,  bp:0, toggle:0, exp_init:1, exp_count:19, exp_first:9'h001};
    vecs[1] = '{cfg:spec_cfg(), npix:4,  bp:0, toggle:0, exp_init:0, exp_count:17, exp_first:9'h02A};
    vecs[2] = '{cfg:spec_cfg(), npix:4,  bp:1, toggle:0, exp_init:0, exp_count:17, exp_first:9'h02A};
    rc = rand_cfg();
    vecs[3] = '{cfg:rc,         npix:1,  bp:0, toggle:0, exp_init:0, exp_count:14, exp_first:{1'b0, rc.op_col}};
    rc = rand_cfg();
    vecs[4] = '{cfg:rc,         npix:12, bp:1, toggle:1, exp_init:0, exp_count:25, exp_first:{1'b0, rc.op_col}};
    vecs[5] = '{cfg:spec_cfg(), npix:6,  bp:1, toggle:1, exp_init:0, exp_count:19, exp_first:9'h02A};
    for (int i = 0; i < 6; i++) run_frame($sformatf("v%0d", i), vecs[i]);

    // Reset while the PASET parameters are being sent.
    v = '{cfg:spec_cfg(), npix:10, bp:0, toggle:0, exp_init:0, exp_count:23, exp_first:9'h02A};
    load_frame(v);
    @(posedge clk); #1; start = 1'b1;
    for (int cyc = 0; cyc < 200 && cap.size() < 7; cyc++) @(negedge clk);
    check("midrst_reached_paset", (cap.size() >= 7), 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_tx_dcx", tx_dcx, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pix_ready", pix_ready, 0);
    check("midrst_frame_done", frame_done, 0);
    pix_q.delete();
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    check("midrst_no_done", fd_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    v = '{cfg:spec_cfg(), npix:3, bp:0, toggle:0, exp_init:1, exp_count:18, exp_first:9'h001};
    run_frame("postrst", v);

    // Random frames.
    for (int k = 0; k < 4; k++) begin
      rc = rand_cfg();
      n  = int'($urandom_range(1, 8));
      v  = '{cfg:rc, npix:n, bp:1'($urandom_range(1)), toggle:0, exp_init:0,
             exp_count:13 + n, exp_first:{1'b0, rc.op_col}};
      run_frame($sformatf("rnd%0d", k), v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
